image_readback_controller: RTL and testbench

Streams the stored image buffer back to the host over the UART byte interface, so the host can read back what was written in. Sits between the UART RX/TX byte ports and the image memory port, in parallel with the write-side streaming controller. Waits for a start byte, then for each buffer byte: fetch from memory, transmit, wait for the host's per-byte ACK. A NAK or any other byte causes a retransmit, with bounded retries.

---
 rtl/image_readback_controller_if.sv | 30 +++
 rtl/image_readback_controller.sv | 181 ++++++++++++++++++
 tb/tb_image_readback_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/image_readback_controller_if.sv
// Bus bundle between the image readback controller and its UART/memory
// neighbours. Signal suffixes are from the controller's point of view.
interface image_readback_controller_if;
  logic [7:0]  rx_data_i;
  logic        rx_ready_i;
  logic        tx_busy_i;
  logic        mem_ready_i;
  logic [7:0]  mem_out_i;
  logic [7:0]  tx_data_o;
  logic        tx_ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        busy_o;
  logic        streaming_ended_o;
  logic        streaming_error_o;

  // Controller side
  modport master (
    input  rx_data_i, rx_ready_i, tx_busy_i, mem_ready_i, mem_out_i,
    output tx_data_o, tx_ready_o, mem_req_o, mem_addr_o,
           busy_o, streaming_ended_o, streaming_error_o
  );

  // Environment side (UART, memory, host status)
  modport slave (
    output rx_data_i, rx_ready_i, tx_busy_i, mem_ready_i, mem_out_i,
    input  tx_data_o, tx_ready_o, mem_req_o, mem_addr_o,
           busy_o, streaming_ended_o, streaming_error_o
  );
endinterface

// File: rtl/image_readback_controller.sv
// Image readback controller: on a START byte, streams every byte of the
// image buffer to the host (fetch, transmit, wait for ACK), resending a
// byte on NAK up to MAX_RETRIES times before aborting.
// Optional feature macro READBACK_CHECKSUM_EN: appends an 8-bit mod-256
// sum of all acknowledged data bytes as a final, also acknowledged, byte.
module image_readback_controller #(
  parameter int IMAGE_BUF_X = 1,
  parameter int IMAGE_BUF_Y = 1,
  parameter int MAX_RETRIES = 3
) (
  input  logic clk,
  input  logic reset,
  image_readback_controller_if.master bus
);

  localparam int unsigned IMAGE_BUF_SIZE = IMAGE_BUF_X * IMAGE_BUF_Y * 2;
  localparam logic [31:0] LAST_ADDR      = 32'(IMAGE_BUF_SIZE - 1);
  localparam logic [7:0]  MAX_R          = 8'(MAX_RETRIES);
  localparam logic [7:0]  START_BYTE     = 8'hAA;
  localparam logic [7:0]  ACK_BYTE       = 8'hAA;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    FETCH        = 3'd1,
    SEND         = 3'd2,
    WAIT_ACK     = 3'd3,
    DONE         = 3'd4,
    ERROR        = 3'd5
`ifdef READBACK_CHECKSUM_EN
    ,
    SEND_SUM     = 3'd6,
    WAIT_SUM_ACK = 3'd7
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_ready_q, tx_ready_d;
  logic        mem_req_q, mem_req_d;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  // State and datapath registers; reset aborts any transfer immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      retry_q    <= '0;
      tx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      mem_req_q  <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      retry_q    <= retry_d;
      tx_data_q  <= tx_data_d;
      tx_ready_q <= tx_ready_d;
      mem_req_q  <= mem_req_d;
`ifdef READBACK_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state and next-output logic for the fetch/send/ack sequence
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    retry_d    = retry_q;
    tx_data_d  = tx_data_q;
    tx_ready_d = tx_ready_q;
    mem_req_d  = mem_req_q;
`ifdef READBACK_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE: begin
        // mem_addr keeps the last address until a new START arrives
        if (bus.rx_ready_i && bus.rx_data_i == START_BYTE) begin
          addr_d    = '0;
          retry_d   = '0;
          mem_req_d = 1'b1;
          state_d   = FETCH;
`ifdef READBACK_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      FETCH: begin
        // Request stays up with a stable address until the data strobe
        if (bus.mem_ready_i) begin
          tx_data_d = bus.mem_out_i;
          mem_req_d = 1'b0;
          state_d   = SEND;
        end
      end
`ifdef READBACK_CHECKSUM_EN
      SEND, SEND_SUM: begin
`else
      SEND: begin
`endif
        // Raise the request only when the UART is idle, then hold it until
        // the UART shows busy, which means the byte was taken
        if (!tx_ready_q) begin
          if (!bus.tx_busy_i) tx_ready_d = 1'b1;
        end else if (bus.tx_busy_i) begin
          tx_ready_d = 1'b0;
          state_d    = WAIT_ACK;
`ifdef READBACK_CHECKSUM_EN
          if (state_q == SEND_SUM) state_d = WAIT_SUM_ACK;
`endif
        end
      end
      WAIT_ACK: begin
        if (bus.rx_ready_i) begin
          if (bus.rx_data_i == ACK_BYTE) begin
            retry_d = '0;
`ifdef READBACK_CHECKSUM_EN
            // Summed only on ACK so resends are counted once
            sum_d = sum_q + tx_data_q;
`endif
            if (addr_q == LAST_ADDR) begin
`ifdef READBACK_CHECKSUM_EN
              tx_data_d = sum_q + tx_data_q;
              state_d   = SEND_SUM;
`else
              state_d   = DONE;
`endif
            end else begin
              addr_d    = addr_q + 32'd1;
              mem_req_d = 1'b1;
              state_d   = FETCH;
            end
          end else if (retry_q < MAX_R) begin
            // Resend the held byte without re-reading memory
            retry_d = retry_q + 8'd1;
            state_d = SEND;
          end else begin
            state_d = ERROR;
          end
        end
      end
`ifdef READBACK_CHECKSUM_EN
      WAIT_SUM_ACK: begin
        if (bus.rx_ready_i) begin
          if (bus.rx_data_i == ACK_BYTE) begin
            state_d = DONE;
          end else if (retry_q < MAX_R) begin
            retry_d = retry_q + 8'd1;
            state_d = SEND_SUM;
          end else begin
            state_d = ERROR;
          end
        end
      end
`endif
      DONE:  state_d = IDLE;
      ERROR: state_d = IDLE;
      default: begin
        tx_ready_d = 1'b0;
        mem_req_d  = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  assign bus.tx_data_o         = tx_data_q;
  assign bus.tx_ready_o        = tx_ready_q;
  assign bus.mem_req_o         = mem_req_q;
  assign bus.mem_addr_o        = addr_q;
  assign bus.busy_o            = (state_q != IDLE);
  assign bus.streaming_ended_o = (state_q == DONE);
  assign bus.streaming_error_o = (state_q == ERROR);

endmodule

// File: tb/tb_image_readback_controller.sv
// Directed bench for image_readback_controller: 2x1 image (4 bytes),
// MAX_RETRIES=2, a 2-cycle memory model and a host/UART model in tasks.
module tb_image_readback_controller;

  logic clk;
  logic reset;
  image_readback_controller_if bus_if ();

  image_readback_controller #(
    .IMAGE_BUF_X(2),
    .IMAGE_BUF_Y(1),
    .MAX_RETRIES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem_image [4];
  int vectors;
  int miscompares;

  // Event counters, written only by the monitor process
  int req_cnt;
  int ended_cnt;
  int err_cnt;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    $display("host -> dut rx 0x%02h", b);
    bus_if.rx_data_i  = b;
    bus_if.rx_ready_i = 1'b1;
    @(negedge clk);
    bus_if.rx_ready_i = 1'b0;
  endtask

  // Wait (bounded) for a transmit request, take the byte, act busy briefly
  task automatic uart_take(output logic [7:0] b, output logic ok);
    int n;
    n = 0;
    while (!bus_if.tx_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = bus_if.tx_ready_o;
    b  = bus_if.tx_data_o;
    if (ok) begin
      $display("dut -> host tx 0x%02h addr %0d", b, bus_if.mem_addr_o);
      bus_if.tx_busy_i = 1'b1;
      repeat (3) @(negedge clk);
      bus_if.tx_busy_i = 1'b0;
    end
  endtask

  task automatic xfer_byte(input string tag, input logic [7:0] exp_b,
                           input logic [31:0] exp_addr, input logic [7:0] reply);
    logic [7:0] b;
    logic ok;
    uart_take(b, ok);
    check_vec({tag, "_tx_seen"}, 32'(ok), 32'd1);
    check_vec({tag, "_tx_byte"}, 32'(b), 32'(exp_b));
    check_vec({tag, "_addr"}, bus_if.mem_addr_o, exp_addr);
    send_rx(reply);
  endtask

  // Finish an image from byte 'first', ACKing everything, and check completion
  task automatic finish_image(input string tag, input int first, input int ended0, input int err0);
    for (int i = first; i < 4; i++) begin
      if (i == 3) check_vec({tag, "_no_early_end"}, 32'(ended_cnt - ended0), 32'd0);
      xfer_byte(tag, mem_image[i], 32'(i), 8'hAA);
    end
`ifdef READBACK_CHECKSUM_EN
    repeat (2) @(negedge clk);
    check_vec({tag, "_no_end_before_sum"}, 32'(ended_cnt - ended0), 32'd0);
    xfer_byte({tag, "_sum"}, 8'hA0, 32'd3, 8'hAA);
`endif
    repeat (4) @(negedge clk);
    check_vec({tag, "_ended"}, 32'(ended_cnt - ended0), 32'd1);
    check_vec({tag, "_no_error"}, 32'(err_cnt - err0), 32'd0);
    check_vec({tag, "_idle"}, 32'(bus_if.busy_o), 32'd0);
    check_vec({tag, "_addr_hold"}, bus_if.mem_addr_o, 32'd3);
  endtask

  // Memory model: one data strobe two cycles after a request is seen
  initial begin
    int lat;
    lat = 0;
    bus_if.mem_ready_i = 1'b0;
    bus_if.mem_out_i   = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_if.mem_ready_i) begin
        bus_if.mem_ready_i = 1'b0;
      end else if (!bus_if.mem_req_o || reset) begin
        lat = 0;
      end else if (lat == 2) begin
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_out_i   = mem_image[bus_if.mem_addr_o[1:0]];
        lat = 0;
      end else begin
        lat++;
      end
    end
  end

  // Monitor: counts request rising edges and status pulse cycles
  initial begin
    logic req_prev;
    req_prev  = 1'b0;
    req_cnt   = 0;
    ended_cnt = 0;
    err_cnt   = 0;
    forever begin
      @(negedge clk);
      if (bus_if.mem_req_o && !req_prev) req_cnt++;
      req_prev = bus_if.mem_req_o;
      if (bus_if.streaming_ended_o) ended_cnt++;
      if (bus_if.streaming_error_o) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, r0, q0, n;
    logic [7:0] b, d0;
    logic ok, flag;

    mem_image[0] = 8'h10;
    mem_image[1] = 8'h20;
    mem_image[2] = 8'h30;
    mem_image[3] = 8'h40;
    vectors     = 0;
    miscompares = 0;
    reset             = 1'b1;
    bus_if.rx_data_i  = 8'h00;
    bus_if.rx_ready_i = 1'b0;
    bus_if.tx_busy_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rst_flags", {27'd0, bus_if.busy_o, bus_if.tx_ready_o, bus_if.mem_req_o,
              bus_if.streaming_ended_o, bus_if.streaming_error_o}, 32'd0);
    check_vec("rst_addr", bus_if.mem_addr_o, 32'd0);
    check_vec("rst_txdata", 32'(bus_if.tx_data_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Non-START bytes are ignored in IDLE
    send_rx(8'h55);
    repeat (3) @(negedge clk);
    check_vec("idle_ignore", {31'd0, bus_if.busy_o}, 32'd0);

    // Scenario 1: plain readback
    e0 = ended_cnt; r0 = err_cnt; q0 = req_cnt;
    send_rx(8'hAA);
    finish_image("s1", 0, e0, r0);
    check_vec("s1_reqs", 32'(req_cnt - q0), 32'd4);

    // Scenario 2: one NAK on byte 1 causes one resend, no extra fetch
    e0 = ended_cnt; r0 = err_cnt; q0 = req_cnt;
    send_rx(8'hAA);
    xfer_byte("s2_b0", 8'h10, 32'd0, 8'hAA);
    xfer_byte("s2_b1", 8'h20, 32'd1, 8'h00);
    xfer_byte("s2_b1_resend", 8'h20, 32'd1, 8'hAA);
    finish_image("s2", 2, e0, r0);
    check_vec("s2_reqs", 32'(req_cnt - q0), 32'd4);

    // Scenario 3: retries exhausted on byte 0
    e0 = ended_cnt; r0 = err_cnt; q0 = req_cnt;
    send_rx(8'hAA);
    for (int i = 0; i < 3; i++) xfer_byte("s3_b0", 8'h10, 32'd0, 8'h55);
    repeat (4) @(negedge clk);
    check_vec("s3_error", 32'(err_cnt - r0), 32'd1);
    check_vec("s3_no_end", 32'(ended_cnt - e0), 32'd0);
    check_vec("s3_idle", {30'd0, bus_if.busy_o, bus_if.tx_ready_o}, 32'd0);
    check_vec("s3_reqs", 32'(req_cnt - q0), 32'd1);

    // Scenario 4: transmitter busy delays the request; request is held
    e0 = ended_cnt; r0 = err_cnt;
    bus_if.tx_busy_i = 1'b1;
    send_rx(8'hAA);
    flag = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.tx_ready_o) flag = 1'b0;
    end
    check_vec("s4_wait_busy", {31'd0, flag}, 32'd1);
    check_vec("s4_busy_state", {31'd0, bus_if.busy_o}, 32'd1);
    bus_if.tx_busy_i = 1'b0;
    n = 0;
    while (!bus_if.tx_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_vec("s4_req_up", {31'd0, bus_if.tx_ready_o}, 32'd1);
    d0 = bus_if.tx_data_o;
    check_vec("s4_byte", 32'(d0), 32'h10);
    flag = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!bus_if.tx_ready_o || bus_if.tx_data_o != d0) flag = 1'b0;
    end
    check_vec("s4_req_held", {31'd0, flag}, 32'd1);
    bus_if.tx_busy_i = 1'b1;
    @(negedge clk);
    check_vec("s4_req_drop", {31'd0, bus_if.tx_ready_o}, 32'd0);
    repeat (2) @(negedge clk);
    bus_if.tx_busy_i = 1'b0;
    send_rx(8'hAA);

    // Scenario 5: reset during the fetch of byte 1, then restart
    n = 0;
    while (!bus_if.mem_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_vec("s5_req_seen", {31'd0, bus_if.mem_req_o}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_vec("s5_rst_flags", {27'd0, bus_if.busy_o, bus_if.tx_ready_o, bus_if.mem_req_o,
              bus_if.streaming_ended_o, bus_if.streaming_error_o}, 32'd0);
    check_vec("s5_rst_addr", bus_if.mem_addr_o, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_vec("s5_no_pulse", 32'((ended_cnt - e0) + (err_cnt - r0)), 32'd0);
    e0 = ended_cnt; r0 = err_cnt;
    send_rx(8'hAA);
    finish_image("s5", 0, e0, r0);

    uart_take(b, ok);
    check_vec("quiet_after", {31'd0, ok}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
